// File: rtl/midi_msg_parser_if.sv
// Byte-stream and decoded-event bundle between the MIDI receiver, the
// message parser and the voice allocator.
interface midi_msg_parser_if;
    logic        i_valid;
    logic [7:0]  i_data;
    logic        o_note_on;
    logic        o_note_off;
    logic        o_cc;
    logic        o_bend_valid;
    logic        o_err;
    logic [3:0]  o_chan;
    logic [6:0]  o_note;
    logic [6:0]  o_vel;
    logic [6:0]  o_cc_num;
    logic [6:0]  o_cc_val;
    logic [13:0] o_bend;

    modport master (
        output i_valid, i_data,
        input  o_note_on, o_note_off, o_cc, o_bend_valid, o_err,
        input  o_chan, o_note, o_vel, o_cc_num, o_cc_val, o_bend
    );

    modport slave (
        input  i_valid, i_data,
        output o_note_on, o_note_off, o_cc, o_bend_valid, o_err,
        output o_chan, o_note, o_vel, o_cc_num, o_cc_val, o_bend
    );
endinterface

// File: rtl/midi_msg_parser.sv
// MIDI byte-to-event decoder with running status, channel filter, realtime skip and SysEx skip.
// Pitch-bend decoding is built only when MIDI_PARSER_BEND_EN is defined.
module midi_msg_parser #(
    parameter logic [3:0] Channel    = 4'd0,
    parameter bit         Omni       = 1'b0,
    parameter bit         VelZeroOff = 1'b1
) (
    input logic               i_clk,
    input logic               i_rst,
    midi_msg_parser_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StData1, StData2, StSkip} state_e;

    state_e      state_q, state_d;
    logic [7:0]  status_q, status_d;
    logic [6:0]  byte1_q, byte1_d;

    logic        is_data, is_chan, is_sys;
    logic        one_byte, chan_ok, take;

    logic        note_on_q, note_on_d;
    logic        note_off_q, note_off_d;
    logic        cc_q, cc_d;
    logic        err_q, err_d;
    logic [3:0]  chan_q, chan_d;
    logic [6:0]  note_q, note_d;
    logic [6:0]  vel_q, vel_d;
    logic [6:0]  cc_num_q, cc_num_d;
    logic [6:0]  cc_val_q, cc_val_d;

    // Realtime bytes (F8-FF) fall in none of these classes and so leave everything untouched.
    assign is_data  = bus.i_valid && !bus.i_data[7];
    assign is_chan  = bus.i_valid && bus.i_data[7] && (bus.i_data[7:4] != 4'hF);
    assign is_sys   = bus.i_valid && (bus.i_data[7:3] == 5'b11110);
    assign one_byte = (status_q[7:5] == 3'b110);
    assign chan_ok  = Omni || (status_q[3:0] == Channel);
    assign take     = is_data && (state_q == StData2) && chan_ok;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= StIdle;
            status_q <= 8'h00;
            byte1_q  <= 7'h00;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            byte1_q  <= byte1_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        byte1_d  = byte1_q;
        if (is_sys) begin
            state_d  = StSkip;
            status_d = 8'h00;
        end else if (is_chan) begin
            state_d  = StData1;
            status_d = bus.i_data;
        end else if (is_data) begin
            case (state_q)
                StData1: begin
                    if (!one_byte) begin
                        byte1_d = bus.i_data[6:0];
                        state_d = StData2;
                    end
                end
                StData2: state_d = StData1;
                default: ;
            endcase
        end
    end

`ifdef MIDI_PARSER_BEND_EN
    logic        bend_valid_q, bend_valid_d;
    logic [13:0] bend_q, bend_d;
`endif

    always_comb begin
        note_on_d  = 1'b0;
        note_off_d = 1'b0;
        cc_d       = 1'b0;
        err_d      = is_data && (state_q == StIdle);
        chan_d     = chan_q;
        note_d     = note_q;
        vel_d      = vel_q;
        cc_num_d   = cc_num_q;
        cc_val_d   = cc_val_q;
`ifdef MIDI_PARSER_BEND_EN
        bend_valid_d = 1'b0;
        bend_d       = bend_q;
`endif
        if (take) begin
            case (status_q[7:4])
                4'h8, 4'h9: begin
                    if (status_q[4] && !(VelZeroOff && (bus.i_data[6:0] == 7'd0))) begin
                        note_on_d = 1'b1;
                    end else begin
                        note_off_d = 1'b1;
                    end
                    chan_d = status_q[3:0];
                    note_d = byte1_q;
                    vel_d  = bus.i_data[6:0];
                end
                4'hB: begin
                    cc_d     = 1'b1;
                    chan_d   = status_q[3:0];
                    cc_num_d = byte1_q;
                    cc_val_d = bus.i_data[6:0];
                end
`ifdef MIDI_PARSER_BEND_EN
                4'hE: begin
                    bend_valid_d = 1'b1;
                    chan_d       = status_q[3:0];
                    bend_d       = {bus.i_data[6:0], byte1_q};
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            note_on_q  <= 1'b0;
            note_off_q <= 1'b0;
            cc_q       <= 1'b0;
            err_q      <= 1'b0;
            chan_q     <= 4'h0;
            note_q     <= 7'h00;
            vel_q      <= 7'h00;
            cc_num_q   <= 7'h00;
            cc_val_q   <= 7'h00;
        end else begin
            note_on_q  <= note_on_d;
            note_off_q <= note_off_d;
            cc_q       <= cc_d;
            err_q      <= err_d;
            chan_q     <= chan_d;
            note_q     <= note_d;
            vel_q      <= vel_d;
            cc_num_q   <= cc_num_d;
            cc_val_q   <= cc_val_d;
        end
    end

`ifdef MIDI_PARSER_BEND_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bend_valid_q <= 1'b0;
            bend_q       <= 14'h2000;
        end else begin
            bend_valid_q <= bend_valid_d;
            bend_q       <= bend_d;
        end
    end

    assign bus.o_bend_valid = bend_valid_q;
    assign bus.o_bend       = bend_q;
`else
    // Bend stays at its centre value when the feature is left out.
    assign bus.o_bend_valid = 1'b0;
    assign bus.o_bend       = 14'h2000;
`endif

    assign bus.o_note_on  = note_on_q;
    assign bus.o_note_off = note_off_q;
    assign bus.o_cc       = cc_q;
    assign bus.o_err      = err_q;
    assign bus.o_chan     = chan_q;
    assign bus.o_note     = note_q;
    assign bus.o_vel      = vel_q;
    assign bus.o_cc_num   = cc_num_q;
    assign bus.o_cc_val   = cc_val_q;

endmodule

// File: doc/midi_msg_parser.md
# midi_msg_parser

Byte-to-message decoder for the synth's MIDI path. Consumes the one-cycle byte strobe from the UART receiver and emits decoded note-on, note-off, control-change and pitch-bend events with registered fields. Supports running status, channel filtering or omni mode, realtime-byte interleaving and SysEx skipping. Sits between the MIDI receiver and the voice allocator, in the same clock domain as the receiver.

## Interface
- Channel, 4'd0, channel to accept when Omni = 0 (0..15, i.e. MIDI channels 1..16)
- Omni, 1'b0, 1 = accept all channels; o_chan reports the source channel
- VelZeroOff, 1'b1, 1 = note-on with velocity 0 is reported as note-off

Ports:
- i_clk  in  1  system clock (single domain)
- i_rst  in  1  reset, synchronous, active-high
- i_valid  in  1  byte strobe, one cycle per received byte; back-to-back cycles allowed
- i_data  in  8  received byte, qualified by i_valid
- o_note_on  out  1  one-cycle event pulse
- o_note_off  out  1  one-cycle event pulse
- o_cc  out  1  one-cycle control-change pulse
- o_bend_valid  out  1  one-cycle pitch-bend pulse
- o_err  out  1  one-cycle pulse: data byte received with no running status
- o_chan  out  4  channel of the last event
- o_note  out  7  note number of the last note event
- o_vel  out  7  velocity of the last note event
- o_cc_num  out  7  controller number of the last CC event
- o_cc_val  out  7  controller value of the last CC event
- o_bend  out  14  pitch-bend value of the last bend event, {MSB, LSB}

## Operation
- States: IDLE (no running status), DATA1, DATA2, SKIP.
- Realtime bytes (F8–FF): ignored in every state. They change neither the state nor the data count.
- System common bytes (F0–F7): clear running status and enter SKIP.
  - SKIP discards data bytes with no o_err.
  - SKIP exits only on the next channel status byte.
- Channel status bytes (80–EF), accepted in any state:
  - Latch the status; go to DATA1.
  - A pending partial message is abandoned with no event.
- Two-data-byte messages: 8n, 9n, An, Bn, En.
  - DATA1 latches byte 1 and goes to DATA2.
  - DATA2 completes the message and returns to DATA1 (running status).
- One-data-byte messages: Cn, Dn. The byte in DATA1 completes the message silently and the state stays DATA1.
- Data byte in IDLE: o_err pulses and the byte is discarded.
- Channel filter: if Omni = 0 and status[3:0] != Channel, bytes are consumed normally but no event or field update occurs.
- Event mapping:
  - 9n with vel > 0 → o_note_on.
  - 9n with vel = 0 → o_note_off when VelZeroOff = 1, otherwise o_note_on.
  - 8n → o_note_off, reporting the received velocity.
  - Bn → o_cc.
  - En → o_bend_valid, with o_bend = {byte2, byte1}.
  - An is consumed with no event.
- Field outputs update only together with their event pulse. They hold otherwise.
- At most one event pulse is high in any cycle.

## Timing
- Event pulse and its fields are registered: they are asserted in the cycle after the cycle in which the final data byte has i_valid = 1. Latency is 1 clock.
- o_err is likewise asserted 1 cycle after the offending byte.
- Pulses are 1 cycle wide. Back-to-back completed messages give pulses in consecutive-or-later cycles with no merging.
- Reset values:
  - All pulses 0; o_chan, o_note, o_vel, o_cc_num, o_cc_val all 0.
  - o_bend 14'h2000; state IDLE; running status cleared.
- Reset asserted mid-message: the partial message is discarded, no event follows, and the state is IDLE on the first cycle after reset.
- i_data is ignored when i_valid = 0.

## Configuration
- MIDI_PARSER_BEND_EN defined: En messages are decoded as above.
- MIDI_PARSER_BEND_EN undefined:
  - En messages are consumed silently; running status and data counting are unchanged.
  - o_bend_valid is tied 0 and o_bend is held at 14'h2000.

## Test plan
- Reset, then bytes 90 3C 64 with Channel = 0 → one o_note_on, o_chan = 0, o_note = 0x3C, o_vel = 0x64, one cycle after the 0x64 strobe.
- Bytes 90 3C 64 40 00 (running status, velocity 0), VelZeroOff = 1 → o_note_on, then o_note_off with o_note = 0x40, o_vel = 0.
- Bytes 91 3C 64 with Channel = 0, Omni = 0 → no pulses. Same stimulus with Omni = 1 → o_note_on, o_chan = 1.
- Bytes B0 07 F8 7F (clock byte mid-message) → o_cc, o_cc_num = 0x07, o_cc_val = 0x7F. Then F0 43 10 F7 12 → no o_err, no events.
- Bytes E0 00 40 → o_bend_valid, o_bend = 14'h2000. Bytes E0 7F 7F → o_bend = 14'h3FFF. Without MIDI_PARSER_BEND_EN → no pulse, o_bend stays 14'h2000.
- Byte 3C after reset → o_err pulse, no event. Bytes 90 3C, then i_rst for 1 cycle, then 64 → o_err, no note event.
